// File: rtl/clint_timer_if.sv
// AXI4-lite bundle (32-bit address and data) between a bus master and the CLINT timer.
interface axi_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/clint_timer.sv
// RISC-V CLINT: 64-bit mtime with prescaler, per-hart mtimecmp/msip, AXI4-lite register access.
module clint_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          NHART     = 1,
    parameter int          TICK_DIV  = 1
) (
    input  logic             clk,
    input  logic             rst,
    axi_if.slave             axi,
    output logic [NHART-1:0] mtip,
    output logic [NHART-1:0] msip,
    output logic [2:0]       dbg_state
);

    // A channel transfers on a rising edge where its valid and ready are both high.
    // The slave keeps a response valid with stable payload until the master's ready.
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RRESP      = 3'd1,
        S_WWAIT_DATA = 3'd2,
        S_WWAIT_ADDR = 3'd3,
        S_WRESP      = 3'd4
    } state_e;

    localparam logic [1:0]  K_MSIP    = 2'd0;
    localparam logic [1:0]  K_CMP     = 2'd1;
    localparam logic [1:0]  K_MTIME   = 2'd2;
    localparam logic [1:0]  RESP_OK   = 2'b00;
    localparam logic [1:0]  RESP_ERR  = 2'b10;
    localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

    typedef struct packed {
        logic       hit;
        logic [1:0] kind;
        logic [1:0] idx;
        logic       hi;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] addr);
        logic [31:0] off;
        dec_t        d;
        d   = '0;
        off = addr - BASE_ADDR;
        if (off[1:0] == 2'b00) begin
            if (off < 32'(4 * NHART)) begin
                d.hit  = 1'b1;
                d.kind = K_MSIP;
                d.idx  = off[3:2];
            end else if (off >= 32'h4000 && off < 32'h4000 + 32'(8 * NHART)) begin
                d.hit  = 1'b1;
                d.kind = K_CMP;
                d.idx  = off[4:3];
                d.hi   = off[2];
            end else if (off[31:3] == 29'h17FF) begin
                d.hit  = 1'b1;
                d.kind = K_MTIME;
                d.hi   = off[2];
            end
        end
        return d;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        end
        return r;
    endfunction

    state_e      state_q;
    logic [31:0] awaddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;

    logic [63:0]      mtime_q, mtime_d;
    logic [15:0]      presc_q, presc_d;
    logic [63:0]      cmp_q [NHART];
    logic [63:0]      cmp_d [NHART];
    logic [NHART-1:0] msip_q, msip_d;
    logic [NHART-1:0] mtip_q, mtip_d;

    dec_t        rd_dec, wr_dec;
    logic [31:0] rd_data;
    logic        wr_en;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;

    // A pending read blocks AW/W acceptance so the read is served first.
    assign axi.arready = (state_q == S_IDLE);
    assign axi.awready = (state_q == S_IDLE && !axi.arvalid) || (state_q == S_WWAIT_ADDR);
    assign axi.wready  = (state_q == S_IDLE && !axi.arvalid) || (state_q == S_WWAIT_DATA);
    assign axi.rvalid  = rvalid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = bresp_q;
    assign mtip        = mtip_q;
    assign msip        = msip_q;
    assign dbg_state   = state_q;

    always_comb begin
        rd_dec  = decode(axi.araddr);
        rd_data = '0;
        if (rd_dec.hit) begin
            unique case (rd_dec.kind)
                K_MSIP: begin
                    for (int h = 0; h < NHART; h++) begin
                        if (rd_dec.idx == 2'(h)) rd_data = {31'b0, msip_q[h]};
                    end
                end
                K_CMP: begin
                    for (int h = 0; h < NHART; h++) begin
                        if (rd_dec.idx == 2'(h)) rd_data = rd_dec.hi ? cmp_q[h][63:32] : cmp_q[h][31:0];
                    end
                end
                default: rd_data = rd_dec.hi ? mtime_q[63:32] : mtime_q[31:0];
            endcase
        end
    end

    // The write commits on the cycle the later of the AW/W handshakes completes.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = axi.awaddr;
        wr_data = axi.wdata;
        wr_strb = axi.wstrb;
        unique case (state_q)
            S_IDLE:       wr_en = !axi.arvalid && axi.awvalid && axi.wvalid;
            S_WWAIT_DATA: begin
                wr_en   = axi.wvalid;
                wr_addr = awaddr_q;
            end
            S_WWAIT_ADDR: begin
                wr_en   = axi.awvalid;
                wr_data = wdata_q;
                wr_strb = wstrb_q;
            end
            default: wr_en = 1'b0;
        endcase
        wr_dec = decode(wr_addr);
    end

    always_comb begin
        presc_d = (presc_q == PRESC_MAX) ? 16'd0 : presc_q + 16'd1;
        mtime_d = (presc_q == PRESC_MAX) ? mtime_q + 64'd1 : mtime_q;
        msip_d  = msip_q;
        cmp_d   = cmp_q;
        if (wr_en && wr_dec.hit) begin
            unique case (wr_dec.kind)
                K_MSIP: begin
                    for (int h = 0; h < NHART; h++) begin
                        if (wr_dec.idx == 2'(h) && wr_strb[0]) msip_d[h] = wr_data[0];
                    end
                end
                K_CMP: begin
                    for (int h = 0; h < NHART; h++) begin
                        if (wr_dec.idx == 2'(h)) begin
                            if (wr_dec.hi) cmp_d[h][63:32] = merge(cmp_q[h][63:32], wr_data, wr_strb);
                            else           cmp_d[h][31:0]  = merge(cmp_q[h][31:0], wr_data, wr_strb);
                        end
                    end
                end
                default: begin
                    // A software write beats the tick; the untouched word keeps its old value.
                    presc_d = 16'd0;
                    if (wr_dec.hi) mtime_d = {merge(mtime_q[63:32], wr_data, wr_strb), mtime_q[31:0]};
                    else           mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], wr_data, wr_strb)};
                end
            endcase
        end
        for (int h = 0; h < NHART; h++) mtip_d[h] = (mtime_q >= cmp_q[h]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime_q <= '0;
            presc_q <= '0;
            msip_q  <= '0;
            mtip_q  <= '0;
            for (int h = 0; h < NHART; h++) cmp_q[h] <= '1;
        end else begin
            mtime_q <= mtime_d;
            presc_q <= presc_d;
            msip_q  <= msip_d;
            mtip_q  <= mtip_d;
            cmp_q   <= cmp_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OK;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OK;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (axi.arvalid) begin
                        rdata_q  <= rd_data;
                        rresp_q  <= rd_dec.hit ? RESP_OK : RESP_ERR;
                        rvalid_q <= 1'b1;
                        state_q  <= S_RRESP;
                    end else if (axi.awvalid && axi.wvalid) begin
                        bresp_q  <= wr_dec.hit ? RESP_OK : RESP_ERR;
                        bvalid_q <= 1'b1;
                        state_q  <= S_WRESP;
                    end else if (axi.awvalid) begin
                        awaddr_q <= axi.awaddr;
                        state_q  <= S_WWAIT_DATA;
                    end else if (axi.wvalid) begin
                        wdata_q  <= axi.wdata;
                        wstrb_q  <= axi.wstrb;
                        state_q  <= S_WWAIT_ADDR;
                    end
                end
                S_RRESP: begin
                    if (axi.rready) begin
                        rvalid_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                S_WWAIT_DATA, S_WWAIT_ADDR: begin
                    if (wr_en) begin
                        bresp_q  <= wr_dec.hit ? RESP_OK : RESP_ERR;
                        bvalid_q <= 1'b1;
                        state_q  <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (axi.bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
// Directed and randomized bench for clint_timer against an arithmetic model of the CLINT.
module tb_clint_timer;

    localparam logic [31:0] BASE   = 32'h0200_0000;
    localparam int          NH     = 2;
    localparam int          TICK_A = 1;
    localparam int          TICK_B = 4;

    // clock / reset
    logic   clk = 1'b0;
    logic   rst;
    longint cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_if bus_a ();
    axi_if bus_b ();
    logic [NH-1:0] mtip_a, msip_a;
    logic [0:0]    mtip_b, msip_b;
    logic [2:0]    dbg_a, dbg_b;

    clint_timer #(.BASE_ADDR(BASE), .NHART(NH), .TICK_DIV(TICK_A)) dut_a (
        .clk(clk), .rst(rst), .axi(bus_a), .mtip(mtip_a), .msip(msip_a), .dbg_state(dbg_a)
    );
    clint_timer #(.BASE_ADDR(BASE), .NHART(1), .TICK_DIV(TICK_B)) dut_b (
        .clk(clk), .rst(rst), .axi(bus_b), .mtip(mtip_b), .msip(msip_b), .dbg_state(dbg_b)
    );

    // scoreboard
    int          tests = 0;
    int          fails = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference model: mtime is an anchor value plus elapsed ticks since the anchor cycle
    logic        m_msip [NH];
    logic [63:0] m_cmp  [NH];
    logic [63:0] m_v;
    longint      m_c;

    function automatic logic [63:0] mtime_at(input longint n);
        return m_v + 64'((n - m_c) / TICK_A);
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] data,
                                                input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset(input longint n);
        for (int h = 0; h < NH; h++) begin
            m_msip[h] = 1'b0;
            m_cmp[h]  = 64'hFFFF_FFFF_FFFF_FFFF;
        end
        m_v = 64'd0;
        m_c = n;
    endtask

    function automatic logic [33:0] model_read(input logic [31:0] addr, input longint n);
        logic [63:0] t;
        t = mtime_at(n);
        for (int h = 0; h < NH; h++) begin
            if (addr == BASE + 32'(4*h))           return {2'b00, 31'b0, m_msip[h]};
            if (addr == BASE + 32'h4000 + 32'(8*h)) return {2'b00, m_cmp[h][31:0]};
            if (addr == BASE + 32'h4004 + 32'(8*h)) return {2'b00, m_cmp[h][63:32]};
        end
        if (addr == BASE + 32'hBFF8) return {2'b00, t[31:0]};
        if (addr == BASE + 32'hBFFC) return {2'b00, t[63:32]};
        return {2'b10, 32'h0};
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb, input longint k);
        logic [63:0] t;
        for (int h = 0; h < NH; h++) begin
            if (addr == BASE + 32'(4*h)) begin
                if (strb[0]) m_msip[h] = data[0];
                return 2'b00;
            end
            if (addr == BASE + 32'h4000 + 32'(8*h)) begin
                m_cmp[h][31:0] = merge_bytes(m_cmp[h][31:0], data, strb);
                return 2'b00;
            end
            if (addr == BASE + 32'h4004 + 32'(8*h)) begin
                m_cmp[h][63:32] = merge_bytes(m_cmp[h][63:32], data, strb);
                return 2'b00;
            end
        end
        if (addr == BASE + 32'hBFF8 || addr == BASE + 32'hBFFC) begin
            t = mtime_at(k);
            if (addr[2]) t[63:32] = merge_bytes(t[63:32], data, strb);
            else         t[31:0]  = merge_bytes(t[31:0], data, strb);
            m_v = t;
            m_c = k + 1;
            return 2'b00;
        end
        return 2'b10;
    endfunction

    task automatic check_irq(input string tag);
        logic [NH-1:0] em_t, em_s;
        logic [63:0]   t;
        if (cyc - 1 < m_c) return;
        t = mtime_at(cyc - 1);
        for (int h = 0; h < NH; h++) begin
            em_t[h] = (t >= m_cmp[h]);
            em_s[h] = m_msip[h];
        end
        check({tag, "_mtip"}, 64'(mtip_a), 64'(em_t));
        check({tag, "_msip"}, 64'(msip_a), 64'(em_s));
    endtask

    // driver tasks (inputs change on the falling edge, outputs sampled there too)
    task automatic axi_read(input logic [31:0] addr, input int rdelay, input string tag);
        logic        hs;
        logic [63:0] e;
        @(negedge clk);
        bus_a.araddr  = addr;
        bus_a.arvalid = 1'b1;
        bus_a.rready  = 1'b0;
        hs = 1'b0;
        for (int t = 0; t < 20 && !hs; t++) begin
            #1;
            if (bus_a.arready) begin
                hs = 1'b1;
                exp_q.push_back(64'(model_read(addr, cyc)));
            end
            @(negedge clk);
        end
        bus_a.arvalid = 1'b0;
        check({tag, "_ar_hs"}, 64'(hs), 64'd1);
        if (!hs) return;
        check({tag, "_rvalid"}, 64'(bus_a.rvalid), 64'd1);
        for (int i = 0; i < rdelay; i++) @(negedge clk);
        bus_a.rready = 1'b1;
        for (int t = 0; t < 20 && !bus_a.rvalid; t++) @(negedge clk);
        e = exp_q.pop_front();
        check({tag, "_rdata"}, 64'(bus_a.rdata), 64'(e[31:0]));
        check({tag, "_rresp"}, 64'(bus_a.rresp), 64'(e[33:32]));
        @(negedge clk);
        bus_a.rready = 1'b0;
    endtask

    // mode 0: AW and W together, 1: AW leads by gap cycles, 2: W leads by gap cycles
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int mode, input int gap, input int bdelay, input string tag);
        logic       aw_done, w_done, aw_fire, w_fire, committed;
        logic [1:0] er;
        @(negedge clk);
        bus_a.awaddr = addr;
        bus_a.wdata  = data;
        bus_a.wstrb  = strb;
        bus_a.bready = 1'b0;
        aw_done = 1'b0;
        w_done  = 1'b0;
        committed = 1'b0;
        er = 2'b00;
        for (int t = 0; t < 40 && !committed; t++) begin
            bus_a.awvalid = !aw_done && (mode != 2 || t >= gap);
            bus_a.wvalid  = !w_done && (mode != 1 || t >= gap);
            #1;
            aw_fire = bus_a.awvalid && bus_a.awready;
            w_fire  = bus_a.wvalid && bus_a.wready;
            if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                committed = 1'b1;
                er = model_write(addr, data, strb, cyc);
            end
            aw_done = aw_done | aw_fire;
            w_done  = w_done | w_fire;
            @(negedge clk);
        end
        bus_a.awvalid = 1'b0;
        bus_a.wvalid  = 1'b0;
        check({tag, "_commit"}, 64'(committed), 64'd1);
        if (!committed) return;
        check({tag, "_bvalid"}, 64'(bus_a.bvalid), 64'd1);
        for (int i = 0; i < bdelay; i++) begin
            @(negedge clk);
            check({tag, "_bhold"}, 64'({bus_a.bvalid, bus_a.bresp}), 64'({1'b1, er}));
        end
        bus_a.bready = 1'b1;
        check({tag, "_bresp"}, 64'(bus_a.bresp), 64'(er));
        @(negedge clk);
        bus_a.bready = 1'b0;
    endtask

    logic [31:0] addrs [12];
    logic [31:0] d;
    logic [1:0]  er;
    logic [63:0] e;
    longint      c0;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        addrs = '{BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'h4000, BASE + 32'h4004,
                  BASE + 32'h4008, BASE + 32'h400C, BASE + 32'h4010, BASE + 32'hBFF8,
                  BASE + 32'hBFFC, BASE + 32'h8000, BASE - 32'h4};
        rst = 1'b0;
        {bus_a.awaddr, bus_a.awvalid, bus_a.wdata, bus_a.wstrb, bus_a.wvalid, bus_a.bready} = '0;
        {bus_a.araddr, bus_a.arvalid, bus_a.rready} = '0;
        {bus_b.awaddr, bus_b.awvalid, bus_b.wdata, bus_b.wstrb, bus_b.wvalid, bus_b.bready} = '0;
        {bus_b.araddr, bus_b.arvalid, bus_b.rready} = '0;
        repeat (3) @(negedge clk);

        check("rst_mtip", 64'(mtip_a), 64'd0);
        check("rst_msip", 64'(msip_a), 64'd0);
        check("rst_valids", 64'({bus_a.rvalid, bus_a.bvalid, bus_a.rdata}), 64'd0);
        check("rst_state", 64'(dbg_a), 64'd0);
        check("rst_b_irq", 64'({mtip_b, msip_b, dbg_b}), 64'd0);
        rst = 1'b1;
        model_reset(cyc);
        c0 = cyc;

        // prescaled mtime on the TICK_DIV=4 instance, 40 cycles after release
        while (cyc < c0 + 40) @(negedge clk);
        bus_b.araddr  = BASE + 32'hBFF8;
        bus_b.arvalid = 1'b1;
        bus_b.rready  = 1'b1;
        #1;
        check("b_arready", 64'(bus_b.arready), 64'd1);
        @(negedge clk);
        bus_b.arvalid = 1'b0;
        check("b_rvalid", 64'(bus_b.rvalid), 64'd1);
        check("b_mtime_lo", 64'(bus_b.rdata), 64'(40 / TICK_B));
        check("b_rresp", 64'(bus_b.rresp), 64'd0);
        @(negedge clk);
        bus_b.rready = 1'b0;

        // msip with and without the byte-0 strobe
        axi_write(BASE + 32'h4, 32'h1, 4'b0001, 0, 0, 0, "msip1_set");
        check("msip_vec", 64'(msip_a), 64'h2);
        axi_write(BASE + 32'h4, 32'h0, 4'b0000, 0, 0, 0, "msip1_nostrb");
        check("msip_vec_hold", 64'(msip_a), 64'h2);
        check_irq("msip");

        // mtimecmp[0]=5 then restart mtime from 0 and watch mtip rise
        axi_write(BASE + 32'h4004, 32'h0, 4'hF, 1, 2, 0, "cmp0_hi");
        axi_write(BASE + 32'h4000, 32'h5, 4'hF, 2, 1, 0, "cmp0_lo");
        axi_write(BASE + 32'hBFF8, 32'h0, 4'hF, 0, 0, 0, "mtime_lo0");
        for (int i = 0; i < 10; i++) begin
            check_irq("mtip_rise");
            @(negedge clk);
        end
        axi_write(BASE + 32'h4004, 32'h1, 4'hF, 0, 0, 0, "cmp0_hi1");
        check_irq("mtip_fall");
        axi_read(BASE + 32'h4004, 1, "cmp0_hi_rd");

        // W three cycles ahead of AW, response held with bready low
        axi_write(BASE + 32'h4008, 32'hA5A5_1234, 4'b0110, 2, 3, 2, "w_first");
        axi_read(BASE + 32'h4008, 0, "w_first_rd");

        // unmapped accesses
        axi_read(BASE + 32'h8000, 0, "unmapped_rd");
        axi_write(BASE + 32'h8, 32'h1, 4'hF, 0, 0, 0, "unmapped_wr");
        check_irq("unmapped");

        // simultaneous read and write: read served, then write
        @(negedge clk);
        bus_a.araddr = BASE;  bus_a.arvalid = 1'b1; bus_a.rready = 1'b1;
        bus_a.awaddr = BASE;  bus_a.wdata = 32'h1;  bus_a.wstrb = 4'h1;
        bus_a.awvalid = 1'b1; bus_a.wvalid = 1'b1;  bus_a.bready = 1'b1;
        #1;
        check("sim_readies", 64'({bus_a.arready, bus_a.awready, bus_a.wready}), 64'b100);
        e = 64'(model_read(BASE, cyc));
        @(negedge clk);
        bus_a.arvalid = 1'b0;
        check("sim_rvalid", 64'(bus_a.rvalid), 64'd1);
        check("sim_rdata", 64'(bus_a.rdata), 64'(e[31:0]));
        @(negedge clk);
        #1;
        check("sim_wreadies", 64'({bus_a.awready, bus_a.wready}), 64'b11);
        er = model_write(BASE, 32'h1, 4'h1, cyc);
        @(negedge clk);
        bus_a.awvalid = 1'b0;
        bus_a.wvalid  = 1'b0;
        check("sim_bvalid", 64'({bus_a.bvalid, bus_a.bresp}), 64'({1'b1, er}));
        @(negedge clk);
        bus_a.bready = 1'b0;
        bus_a.rready = 1'b0;
        check_irq("sim");

        // mtime wrap through all-ones
        axi_write(BASE + 32'hBFFC, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, "mtime_hi_ones");
        axi_write(BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, "mtime_lo_ones");
        check_irq("wrap");
        axi_read(BASE + 32'hBFFC, 0, "wrap_hi");
        axi_read(BASE + 32'hBFF8, 0, "wrap_lo");

        // randomized traffic
        for (int i = 0; i < 70; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                axi_read(addrs[$urandom_range(0, 11)], $urandom_range(0, 2), "rnd_rd");
            end else begin
                d = $urandom;
                if ($urandom_range(0, 1) == 1) d = 32'($urandom_range(0, 3));
                axi_write(addrs[$urandom_range(0, 11)], d, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2), "rnd_wr");
            end
            check_irq("rnd");
        end

        // reset while a write response is pending
        @(negedge clk);
        bus_a.awaddr = BASE + 32'h4000; bus_a.wdata = 32'h1234; bus_a.wstrb = 4'hF;
        bus_a.awvalid = 1'b1; bus_a.wvalid = 1'b1; bus_a.bready = 1'b0;
        @(negedge clk);
        bus_a.awvalid = 1'b0;
        bus_a.wvalid  = 1'b0;
        check("rst_pre_bvalid", 64'(bus_a.bvalid), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        check("rst_bvalid", 64'(bus_a.bvalid), 64'd0);
        check("rst_state_mid", 64'(dbg_a), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset(cyc);
        axi_read(BASE + 32'h4000, 0, "rst_cmp_lo");
        axi_read(BASE + 32'h4004, 0, "rst_cmp_hi");
        check_irq("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
